// File: rtl/mat_inv_2x2.sv
// mat_inv_2x2: 2x2 signed Q8.8 matrix inverse with a shared 32-step restoring divider
module mat_inv_2x2 #(
  parameter int FRAC_BITS = 8
) (
  input  logic               I_sys_clk,
  input  logic               I_sys_rstn,
  input  logic signed [15:0] a11_keep,
  input  logic signed [15:0] a12_keep,
  input  logic signed [15:0] a21_keep,
  input  logic signed [15:0] a22_keep,
  input  logic               rx_valid,
  output logic signed [15:0] b11,
  output logic signed [15:0] b12,
  output logic signed [15:0] b21,
  output logic signed [15:0] b22,
  output logic               inv_valid,
  output logic               singular,
  output logic               busy
);
  typedef enum logic [2:0] {IDLE, MUL, DET, DIV, STORE, OUT, SING} state_t;
  state_t r_st;
  logic signed [15:0] r_x [4];
  logic signed [15:0] r_e [4];
  logic signed [31:0] r_p1, r_p2;
  logic [31:0] r_d, r_q, r_r;
  logic [4:0] r_cnt;
  logic [1:0] r_k;
  logic r_dneg, r_rx_d;
  logic w_start, w_ge, w_neg;
  logic signed [32:0] w_det;
  logic [31:0] w_dmag, w_num, w_sub;
  logic [32:0] w_t;
  logic [1:0] w_kn;
  logic [15:0] w_x, w_abs, w_qn, w_res;
  // r_x holds numerators in output order: a22, a12, a21, a11
  always_comb begin
    w_start = rx_valid & ~r_rx_d & (r_st == IDLE);
    w_det = {r_p1[31], r_p1} - {r_p2[31], r_p2};
    w_dmag = w_det[32] ? 32'd0 - w_det[31:0] : w_det[31:0];
    w_kn = (r_st == STORE) ? r_k + 2'd1 : r_k;
    w_x = r_x[w_kn];
    w_abs = w_x[15] ? 16'd0 - w_x : w_x;
    w_num = 32'(w_abs) << (2 * FRAC_BITS);
    w_t = {r_r, r_q[31]};
    w_ge = w_t >= {1'b0, r_d};
    w_sub = w_t[31:0] - r_d;
    w_neg = r_x[r_k][15] ^ r_dneg ^ r_k[0] ^ r_k[1];
    w_qn = 16'd0 - r_q[15:0];
    w_res = w_neg ? (r_q > 32'd32768 ? 16'h8000 : w_qn) : (r_q > 32'd32767 ? 16'h7FFF : r_q[15:0]);
  end
  always_ff @(posedge I_sys_clk or negedge I_sys_rstn)
    if (!I_sys_rstn) begin
      r_st <= IDLE;
      r_x <= '{default: '0};
      r_e <= '{default: '0};
      r_p1 <= '0;
      r_p2 <= '0;
      r_d <= '0;
      r_q <= '0;
      r_r <= '0;
      r_cnt <= '0;
      r_k <= '0;
      r_dneg <= 1'b0;
      r_rx_d <= 1'b0;
      b11 <= '0;
      b12 <= '0;
      b21 <= '0;
      b22 <= '0;
      inv_valid <= 1'b0;
      singular <= 1'b0;
      busy <= 1'b0;
    end else begin
      r_rx_d <= rx_valid;
      inv_valid <= 1'b0;
      case (r_st)
        IDLE: begin
          busy <= w_start;
          if (w_start) begin
            r_x <= '{a22_keep, a12_keep, a21_keep, a11_keep};
            r_k <= 2'd0;
            r_st <= MUL;
          end
        end
        MUL: begin
          r_p1 <= 32'(r_x[3]) * 32'(r_x[0]);
          r_p2 <= 32'(r_x[1]) * 32'(r_x[2]);
          r_st <= DET;
        end
        DET:
          if (w_det == 33'sd0) r_st <= SING;
          else begin
            r_d <= w_dmag;
            r_dneg <= w_det[32];
            r_q <= w_num;
            r_r <= '0;
            r_cnt <= '0;
            r_st <= DIV;
          end
        DIV: begin
          r_r <= w_ge ? w_sub : w_t[31:0];
          r_q <= {r_q[30:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_st <= STORE;
        end
        STORE: begin
          r_e[r_k] <= w_res;
          r_k <= r_k + 2'd1;
          r_q <= w_num;
          r_r <= '0;
          r_st <= (r_k == 2'd3) ? OUT : DIV;
        end
        OUT: begin
          b11 <= r_e[0];
          b12 <= r_e[1];
          b21 <= r_e[2];
          b22 <= r_e[3];
          singular <= 1'b0;
          inv_valid <= 1'b1;
          r_st <= IDLE;
        end
        SING: begin
          b11 <= '0;
          b12 <= '0;
          b21 <= '0;
          b22 <= '0;
          singular <= 1'b1;
          inv_valid <= 1'b1;
          r_st <= IDLE;
        end
        default: r_st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mat_inv_2x2.sv
// tb_mat_inv_2x2: directed vectors with hand-computed inverses, latency and control checks
module tb_mat_inv_2x2;
  logic clk = 1'b0, rstn = 1'b0, rx_valid = 1'b0;
  logic [15:0] a11 = '0, a12 = '0, a21 = '0, a22 = '0;
  logic [15:0] b11, b12, b21, b22;
  logic inv_valid, singular, busy;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mat_inv_2x2 dut (
    .I_sys_clk(clk), .I_sys_rstn(rstn),
    .a11_keep(a11), .a12_keep(a12), .a21_keep(a21), .a22_keep(a22),
    .rx_valid(rx_valid),
    .b11(b11), .b12(b12), .b21(b21), .b22(b22),
    .inv_valid(inv_valid), .singular(singular), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [15:0] e11, e12, e21, e22, input logic es);
    chk({tag, " b11"}, b11, e11);
    chk({tag, " b12"}, b12, e12);
    chk({tag, " b21"}, b21, e21);
    chk({tag, " b22"}, b22, e22);
    chk({tag, " singular"}, singular, es);
  endtask
  task automatic run(input string tag, input logic [15:0] x11, x12, x21, x22, input int lat,
                     input logic [15:0] e11, e12, e21, e22, input logic es);
    int n;
    @(negedge clk);
    a11 = x11; a12 = x12; a21 = x21; a22 = x22; rx_valid = 1'b1;
    @(posedge clk); #1;
    chk({tag, " busy start"}, busy, 1);
    n = 0;
    while (!inv_valid && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " busy at valid"}, busy, 1);
    chk_out(tag, e11, e12, e21, e22, es);
    @(posedge clk); #1;
    chk({tag, " pulse width"}, inv_valid, 0);
    chk({tag, " busy end"}, busy, 0);
    @(negedge clk) rx_valid = 1'b0;
  endtask
  initial begin
    int n, extra;
    #12;
    chk_out("reset", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("reset inv_valid", inv_valid, 0);
    chk("reset busy", busy, 0);
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(negedge clk);
    run("identity", 16'h0100, 16'h0000, 16'h0000, 16'h0100, 135, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 1'b0);
    run("general", 16'h0100, 16'h0200, 16'h0300, 16'h0400, 135, 16'hFE00, 16'h0100, 16'h0180, 16'hFF80, 1'b0);
    run("singular", 16'h0100, 16'h0200, 16'h0200, 16'h0400, 3, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    run("identity2", 16'h0100, 16'h0000, 16'h0000, 16'h0100, 135, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 1'b0);
    run("saturate", 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 135, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000, 1'b0);
    @(negedge clk);
    a11 = 16'h0200; a12 = 16'h0000; a21 = 16'h0000; a22 = 16'h0400; rx_valid = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!inv_valid && n < 300) begin
      @(posedge clk); #1; n++;
      if (n == 45) rx_valid = 1'b0;
      if (n == 49) begin rx_valid = 1'b1; a11 = 16'h0100; a22 = 16'h0100; end
      if (n == 59) rx_valid = 1'b0;
    end
    chk("retrig latency", n, 135);
    chk_out("retrig", 16'h0080, 16'h0000, 16'h0000, 16'h0040, 1'b0);
    extra = 0;
    repeat (150) begin
      @(posedge clk); #1;
      extra += int'(inv_valid) + int'(busy);
    end
    chk("retrig no second run", extra, 0);
    @(negedge clk);
    a11 = 16'h0100; a12 = 16'h0200; a21 = 16'h0300; a22 = 16'h0400; rx_valid = 1'b1;
    @(posedge clk); #1;
    repeat (70) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk_out("midreset", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("midreset busy", busy, 0);
    chk("midreset inv_valid", inv_valid, 0);
    rx_valid = 1'b0;
    @(negedge clk) rstn = 1'b1;
    extra = 0;
    repeat (140) begin
      @(posedge clk); #1;
      extra += int'(inv_valid);
    end
    chk("midreset no valid", extra, 0);
    run("after reset", 16'h0100, 16'h0200, 16'h0300, 16'h0400, 135, 16'hFE00, 16'h0100, 16'h0180, 16'hFF80, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
